// File: rtl/bcd_scan_display_driver.sv
// Multiplexed seven-segment driver: converts a binary value to BCD one double-dabble
// step per clock, then scans the committed digits onto common-anode display pins.
module bcd_scan_display_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int VALUE_WIDTH  = 14,
   parameter int DIGIT_PERIOD = 32768
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [VALUE_WIDTH-1:0] value,
   input  logic                   load,
   input  logic                   blank_leading,
   input  logic [NUM_DIGITS-1:0]  dp_mask,
   input  logic                   enable,
   output logic                   busy,
   output logic                   overflow,
   output logic [NUM_DIGITS-1:0]  anode_signals,
   output logic [6:0]             display_out,
   output logic                   dp_out
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(VALUE_WIDTH);
   localparam int PER_W = $clog2(DIGIT_PERIOD);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(VALUE_WIDTH - 1);
   localparam logic [PER_W-1:0] LAST_COUNT = PER_W'(DIGIT_PERIOD - 1);
   localparam logic [IDX_W-1:0] MSD_INDEX  = IDX_W'(NUM_DIGITS - 1);

   logic [VALUE_WIDTH-1:0] shift_reg;
   logic [BCD_W-1:0]       bcd_reg;
   logic                   ovf_acc_reg;
   logic [CNT_W-1:0]       iter_reg;
   logic                   busy_reg;
   logic [BCD_W-1:0]       digits_reg;
   logic                   overflow_reg;
   logic [PER_W-1:0]       period_reg;
   logic [IDX_W-1:0]       scan_idx_reg;
   logic [NUM_DIGITS-1:0]  anode_reg;
   logic [6:0]             seg_reg;
   logic                   dp_reg;

   logic [BCD_W-1:0]       bcd_adj_next;
   logic [BCD_W-1:0]       bcd_next;
   logic                   shifted_out_next;
   logic [NUM_DIGITS:0]    upper_zero_next;
   logic [3:0]             digit_arr [NUM_DIGITS];
   logic                   blank_arr [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]  anode_next;
   logic [6:0]             seg_next;
   logic                   dp_next;

   function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
      case (nibble)
         4'd0:    seg_decode = 7'b0000001;
         4'd1:    seg_decode = 7'b1001111;
         4'd2:    seg_decode = 7'b0010010;
         4'd3:    seg_decode = 7'b0000110;
         4'd4:    seg_decode = 7'b1001100;
         4'd5:    seg_decode = 7'b0100100;
         4'd6:    seg_decode = 7'b0100000;
         4'd7:    seg_decode = 7'b0001111;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0000100;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   // upper_zero_next[i] is 1 when digit i and every more significant digit are zero.
   assign upper_zero_next[NUM_DIGITS] = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign bcd_adj_next[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                          bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
         assign digit_arr[gi]           = digits_reg[gi*4 +: 4];
         assign upper_zero_next[gi]     = upper_zero_next[gi+1] && (digits_reg[gi*4 +: 4] == 4'd0);
         assign blank_arr[gi]           = blank_leading && (gi != 0) && upper_zero_next[gi];
      end
   endgenerate

   assign bcd_next         = {bcd_adj_next[BCD_W-2:0], shift_reg[VALUE_WIDTH-1]};
   assign shifted_out_next = bcd_adj_next[BCD_W-1];

   always_comb begin
      anode_next = '1;
      dp_next    = 1'b1;
      if (overflow_reg)
         seg_next = 7'b1111110;
      else if (blank_arr[scan_idx_reg])
         seg_next = 7'b1111111;
      else
         seg_next = seg_decode(digit_arr[scan_idx_reg]);
      if (enable) begin
         anode_next[scan_idx_reg] = 1'b0;
         dp_next                  = ~dp_mask[scan_idx_reg];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shift_reg    <= '0;
         bcd_reg      <= '0;
         ovf_acc_reg  <= 1'b0;
         iter_reg     <= '0;
         busy_reg     <= 1'b0;
         digits_reg   <= '0;
         overflow_reg <= 1'b0;
         period_reg   <= '0;
         scan_idx_reg <= MSD_INDEX;
         anode_reg    <= '1;
         seg_reg      <= 7'b1111111;
         dp_reg       <= 1'b1;
      end else begin
         if (busy_reg) begin
            shift_reg   <= shift_reg << 1;
            bcd_reg     <= bcd_next;
            ovf_acc_reg <= ovf_acc_reg | shifted_out_next;
            if (iter_reg == '0) begin
               busy_reg     <= 1'b0;
               digits_reg   <= bcd_next;
               overflow_reg <= ovf_acc_reg | shifted_out_next;
            end else begin
               iter_reg <= iter_reg - 1'b1;
            end
         end else if (load) begin
            shift_reg   <= value;
            bcd_reg     <= '0;
            ovf_acc_reg <= 1'b0;
            iter_reg    <= LAST_ITER;
            busy_reg    <= 1'b1;
         end

         if (period_reg == LAST_COUNT) begin
            period_reg   <= '0;
            scan_idx_reg <= (scan_idx_reg == '0) ? MSD_INDEX : scan_idx_reg - 1'b1;
         end else begin
            period_reg <= period_reg + 1'b1;
         end

         anode_reg <= anode_next;
         seg_reg   <= seg_next;
         dp_reg    <= dp_next;
      end
   end

   assign busy          = busy_reg;
   assign overflow      = overflow_reg;
   assign anode_signals = anode_reg;
   assign display_out   = seg_reg;
   assign dp_out        = dp_reg;

endmodule

// File: tb/tb_bcd_scan_display_driver.sv
// Directed bench for bcd_scan_display_driver with NUM_DIGITS=4, VALUE_WIDTH=14, DIGIT_PERIOD=4.
module tb_bcd_scan_display_driver;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [13:0] value = '0;
   logic        load = 1'b0;
   logic        blank_leading = 1'b0;
   logic [3:0]  dp_mask = '0;
   logic        enable = 1'b1;
   logic        busy;
   logic        overflow;
   logic [3:0]  anode_signals;
   logic [6:0]  display_out;
   logic        dp_out;

   int checks = 0;
   int errors = 0;

   logic [6:0] cap_seg [4];
   logic       cap_dp [4];
   logic [3:0] cap_anode [20];
   bit         cap_order_ok;

   bcd_scan_display_driver #(
      .NUM_DIGITS(4),
      .VALUE_WIDTH(14),
      .DIGIT_PERIOD(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .value(value),
      .load(load),
      .blank_leading(blank_leading),
      .dp_mask(dp_mask),
      .enable(enable),
      .busy(busy),
      .overflow(overflow),
      .anode_signals(anode_signals),
      .display_out(display_out),
      .dp_out(dp_out)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Loads v and returns the number of cycles busy stayed high (bounded).
   task automatic load_and_wait(input logic [13:0] v, output int n);
      value = v;
      load  = 1'b1;
      @(negedge clock);
      load = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clock);
      end
   endtask

   // Watches 20 cycles after one settling cycle; records segments/dp per visible digit.
   task automatic capture();
      logic [3:0] prev;
      int d;
      for (int i = 0; i < 4; i++) begin
         cap_seg[i] = 'x;
         cap_dp[i]  = 1'bx;
      end
      cap_order_ok = 1'b1;
      prev = 4'b1111;
      @(negedge clock);
      for (int t = 0; t < 20; t++) begin
         @(negedge clock);
         cap_anode[t] = anode_signals;
         case (anode_signals)
            4'b1110: d = 0;
            4'b1101: d = 1;
            4'b1011: d = 2;
            4'b0111: d = 3;
            default: d = -1;
         endcase
         if (d < 0) cap_order_ok = 1'b0;
         else begin
            cap_seg[d] = display_out;
            cap_dp[d]  = dp_out;
         end
         if (prev != 4'b1111 && anode_signals != prev && anode_signals != {prev[0], prev[3:1]})
            cap_order_ok = 1'b0;
         prev = anode_signals;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (anode_signals !== 4'b1111) begin
         errors++; $display("FAIL reset_anode: got %b, expected 1111", anode_signals);
      end
      checks++;
      if (display_out !== 7'b1111111) begin
         errors++; $display("FAIL reset_segments: got %b, expected 1111111", display_out);
      end
      checks++;
      if (busy !== 1'b0 || overflow !== 1'b0 || dp_out !== 1'b1) begin
         errors++; $display("FAIL reset_flags: got busy=%b ovf=%b dp=%b, expected 0 0 1", busy, overflow, dp_out);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (anode_signals !== 4'b0111) begin
         errors++; $display("FAIL first_scan: got %b, expected 0111", anode_signals);
      end
   endtask

   task automatic test_convert_1234();
      int n;
      logic [6:0] exp_seg [4];
      exp_seg[3] = 7'b1001111; exp_seg[2] = 7'b0010010;
      exp_seg[1] = 7'b0000110; exp_seg[0] = 7'b1001100;
      blank_leading = 1'b0;
      dp_mask = 4'b0000;
      load_and_wait(14'd1234, n);
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL busy_len_1234: got %0d cycles, expected 14", n);
      end
      capture();
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== 1'b1) begin
            errors++; $display("FAIL digit%0d_1234: got seg=%b dp=%b, expected seg=%b dp=1", d, cap_seg[d], cap_dp[d], exp_seg[d]);
         end
      end
      checks++;
      if (!cap_order_ok) begin
         errors++; $display("FAIL scan_order_1234: got out-of-order anodes, expected 0111->1011->1101->1110");
      end
      for (int t = 0; t < 4; t++) begin
         checks++;
         if (cap_anode[t] !== cap_anode[t+16]) begin
            errors++; $display("FAIL scan_period_%0d: got %b, expected %b", t, cap_anode[t+16], cap_anode[t]);
         end
      end
   endtask

   task automatic test_blank_dp();
      int n;
      logic [6:0] exp_seg [4];
      exp_seg[3] = 7'b1111111; exp_seg[2] = 7'b1111111;
      exp_seg[1] = 7'b1111111; exp_seg[0] = 7'b0001111;
      blank_leading = 1'b1;
      dp_mask = 4'b0100;
      load_and_wait(14'd7, n);
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL busy_len_7: got %0d cycles, expected 14", n);
      end
      capture();
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== (d == 2 ? 1'b0 : 1'b1)) begin
            errors++; $display("FAIL digit%0d_blank7: got seg=%b dp=%b, expected seg=%b dp=%b", d, cap_seg[d], cap_dp[d], exp_seg[d], (d == 2 ? 1'b0 : 1'b1));
         end
      end
      dp_mask = 4'b0000;
   endtask

   task automatic test_overflow();
      int n;
      blank_leading = 1'b1;
      load_and_wait(14'd10000, n);
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL overflow_set: got %b, expected 1", overflow);
      end
      capture();
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (cap_seg[d] !== 7'b1111110) begin
            errors++; $display("FAIL digit%0d_dash: got %b, expected 1111110", d, cap_seg[d]);
         end
      end
      load_and_wait(14'd0, n);
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL overflow_clear: got %b, expected 0", overflow);
      end
      capture();
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (cap_seg[d] !== (d == 0 ? 7'b0000001 : 7'b1111111)) begin
            errors++; $display("FAIL digit%0d_zero: got %b, expected %b", d, cap_seg[d], (d == 0 ? 7'b0000001 : 7'b1111111));
         end
      end
   endtask

   task automatic test_load_while_busy();
      int n;
      logic [6:0] exp_seg [4];
      exp_seg[3] = 7'b0000001; exp_seg[2] = 7'b0000001;
      exp_seg[1] = 7'b1001100; exp_seg[0] = 7'b0010010;
      blank_leading = 1'b0;
      value = 14'd42;
      load  = 1'b1;
      @(negedge clock);
      load = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         if (n == 3) begin value = 14'd99; load = 1'b1; end
         if (n == 6) load = 1'b0;
         @(negedge clock);
      end
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL busy_len_42: got %0d cycles, expected 14", n);
      end
      capture();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL no_queued_load: got busy=%b, expected 0", busy);
      end
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (cap_seg[d] !== exp_seg[d]) begin
            errors++; $display("FAIL digit%0d_0042: got %b, expected %b", d, cap_seg[d], exp_seg[d]);
         end
      end
   endtask

   task automatic test_reset_mid_conversion();
      value = 14'd9999;
      load  = 1'b1;
      @(negedge clock);
      load = 1'b0;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || anode_signals !== 4'b1111 || display_out !== 7'b1111111) begin
         errors++; $display("FAIL mid_reset: got busy=%b anode=%b seg=%b, expected 0 1111 1111111", busy, anode_signals, display_out);
      end
      reset = 1'b0;
      capture();
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (cap_seg[d] !== 7'b0000001) begin
            errors++; $display("FAIL digit%0d_after_reset: got %b, expected 0000001", d, cap_seg[d]);
         end
      end
   endtask

   task automatic test_enable();
      logic [3:0] prev;
      int k;
      bit found;
      dp_mask = 4'b1111;
      prev  = anode_signals;
      found = 1'b0;
      k = 0;
      while (!found && k < 40) begin
         @(negedge clock);
         if (anode_signals == 4'b0111 && prev == 4'b1110) found = 1'b1;
         prev = anode_signals;
         k++;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL enable_sync: got no 1110->0111 transition, expected one within 40 cycles");
      end
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         checks++;
         if (anode_signals !== 4'b1111 || dp_out !== 1'b1) begin
            errors++; $display("FAIL disabled_%0d: got anode=%b dp=%b, expected 1111 1", i, anode_signals, dp_out);
         end
      end
      enable = 1'b1;
      @(negedge clock);
      checks++;
      if (anode_signals !== 4'b1011 || dp_out !== 1'b0) begin
         errors++; $display("FAIL enable_resume: got anode=%b dp=%b, expected 1011 0", anode_signals, dp_out);
      end
      dp_mask = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_convert_1234();
      test_blank_dp();
      test_overflow();
      test_load_while_busy();
      test_reset_mid_conversion();
      test_enable();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
